allophone_sequencer: RTL and testbench
======================================

Name: allophone_sequencer

Overview:
Front-end initiator for the speech playback core. It walks a phrase list in a phrase ROM (BRAM, 2-cycle read latency) and hands allophone codes one at a time to the playback core. The handshake uses the core's data_arrived and busy signals: one pulse per allophone, then the block waits for busy to rise and fall before issuing the next. It sits between the user command logic (start plus phrase address) and the playback core.

Parameters:
ADDR_W, 10, phrase ROM address width; addresses wrap modulo 2^ADDR_W.
MAX_LEN, 32, maximum allophones per phrase before forced termination.
ACK_TIMEOUT, 15, cycles allowed after data_arrived for the core to raise busy.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
start  in  1  single-cycle request to speak the phrase at phrase_addr; ignored unless seq_busy=0
phrase_addr  in  ADDR_W  first ROM address of the phrase, sampled when start is accepted
rom_addr  out  ADDR_W  phrase ROM read address
rom_data  in  8  phrase ROM data, valid 2 cycles after rom_addr changes
core_busy  in  1  busy output of the playback core
allophone  out  6  allophone code presented to the core
data_arrived  out  1  one-cycle pulse: allophone is valid, core may start
seq_busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at phrase end
error  out  1  sticky status for the last phrase; cleared on the next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; rom_addr=0, allophone=0, data_arrived=0, seq_busy=0, done=0, error=0, length counter=0, timeout counter=0.
- ROM data encoding:
  - 0x00-0x3F: allophone code (low 6 bits).
  - 0xFF: terminator.
  - 0x40-0xFE: invalid. Set error, skip the entry, count it toward MAX_LEN.
- States and transitions:
  - IDLE: seq_busy=0. On start: rom_addr<=phrase_addr, len<=0, error<=0, go to ROM1.
  - ROM1 -> ROM2 -> DECODE: unconditional, one cycle each, covering the BRAM latency.
  - DECODE:
    - 0xFF: go to FINISH.
    - Invalid code: set error, go to NEXT.
    - Valid code: allophone<=rom_data[5:0], go to WAIT_IDLE.
  - WAIT_IDLE: remain while core_busy=1. When core_busy=0, go to ISSUE.
  - ISSUE: data_arrived=1 for exactly this cycle. Clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK:
    - core_busy=1: go to WAIT_DONE.
    - Otherwise increment the timeout counter.
    - Counter reaches ACK_TIMEOUT: set error, go to FINISH.
  - WAIT_DONE: remain while core_busy=1. When core_busy=0, go to NEXT.
  - NEXT: rom_addr<=rom_addr+1 (wraps), len<=len+1.
    - len+1==MAX_LEN: set error, go to FINISH.
    - Otherwise go to ROM1.
  - FINISH: done=1 for one cycle, go to IDLE.
- seq_busy=1 in every state except IDLE. A start while seq_busy=1 is ignored.
- allophone is held stable from ISSUE until the next DECODE update. It must not change while core_busy=1.
- Latency: start to first data_arrived is 5 cycles when core_busy=0 (start cycle, ROM1, ROM2, DECODE, WAIT_IDLE, then ISSUE).
- An empty phrase (first entry 0xFF) produces done 4 cycles after start, with no data_arrived and error=0.
- If core_busy rises and falls in the same window as WAIT_ACK entry, it is still seen because WAIT_ACK samples every cycle. The core holds busy for at least 4 cycles, so no pulse is missed.
- Reset asserted mid-phrase aborts immediately. No done pulse is generated, and the core is left to finish its current allophone on its own.

Decomposition:
- Shared package:
  - State enum, encoded 4 bits.
  - Constants TERMINATOR=8'hFF and ALLO_MAX=6'h3F.
  - ROM read-latency constant = 2, shared with the playback core's delay states.
- One natural sub-module: seq_timeout_counter (clear/enable/expired).
- The address pointer and length counter stay inline.

Test Plan:
- Phrase at 0x010 = {0x05,0x1A,0xFF}, core model busy 20 cycles per code -> data_arrived twice, allophone 0x05 then 0x1A, done once, error=0, rom_addr ends at 0x012.
- Phrase at 0x3FE = {0x07,0x08,0xFF} -> rom_addr wraps 0x3FF->0x000, three ROM reads, codes 0x07 then 0x08, done, error=0.
- Phrase {0x05,0x80,0x06,0xFF} -> codes 0x05 and 0x06 issued, 0x80 skipped, error=1 after done.
- 40 entries of 0x01, no terminator, MAX_LEN=32 -> exactly 32 data_arrived pulses, then done, error=1.
- Core model never raises busy -> one data_arrived, then done 15 cycles later, error=1. start held during the phrase is ignored.
- Reset asserted while in WAIT_DONE -> all outputs 0 in the same cycle. A new start after release speaks the phrase from its beginning.

Source files
------------

// File: rtl/allophone_sequencer_pkg.sv
// Shared types and constants for the allophone sequencer and its neighbours.
package allophone_sequencer_pkg;

    // Sequencer states, 4-bit encoding.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ROM1      = 4'd1,
        S_ROM2      = 4'd2,
        S_DECODE    = 4'd3,
        S_WAIT_IDLE = 4'd4,
        S_ISSUE     = 4'd5,
        S_WAIT_ACK  = 4'd6,
        S_WAIT_DONE = 4'd7,
        S_NEXT      = 4'd8,
        S_FINISH    = 4'd9
    } seq_state_e;

    // End-of-phrase marker in the phrase ROM.
    localparam logic [7:0] TERMINATOR = 8'hFF;

    // Highest legal allophone code.
    localparam logic [5:0] ALLO_MAX = 6'h3F;

    // Phrase ROM read latency in cycles (ROM1 + ROM2); the playback core
    // uses the same figure for its own delay states.
    localparam int ROM_LATENCY = 2;

    // True when a ROM byte carries a playable allophone code.
    function automatic logic is_allophone(input logic [7:0] d);
        return d <= {2'b00, ALLO_MAX};
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Cycle counter used to bound how long the sequencer waits for the core to
// acknowledge an allophone. expired_o rises on the LIMIT-th enabled cycle
// after a clear and the count then holds.
module seq_timeout_counter #(
    parameter int LIMIT = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = (count_q == CW'(LIMIT - 1));

    // Next count: clear wins, otherwise count enabled cycles until expiry.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/allophone_sequencer.sv
// Walks a phrase in the phrase ROM and hands allophones one at a time to
// the speech playback core using its data_arrived / busy handshake.
module allophone_sequencer
    import allophone_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int MAX_LEN     = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] phrase_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              core_busy,
    output logic [5:0]        allophone,
    output logic              data_arrived,
    output logic              seq_busy,
    output logic              done,
    output logic              error
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [5:0]        allo_q, allo_d;
    logic              err_q, err_d;
    logic              to_clear;
    logic              to_en;
    logic              to_expired;

    // The ISSUE cycle is the first cycle of the acknowledge window, so the
    // counter only has to cover the remaining WAIT_ACK cycles; this puts
    // done exactly ACK_TIMEOUT cycles after data_arrived on a timeout.
    seq_timeout_counter #(
        .LIMIT (ACK_TIMEOUT - 1)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (to_clear),
        .enable_i  (to_en),
        .expired_o (to_expired)
    );

    // Next-state logic for the phrase walk and handshake.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        allo_d   = allo_q;
        err_d    = err_q;
        to_clear = 1'b0;
        to_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = phrase_addr;
                    len_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_ROM1;
                end
            end
            S_ROM1:  state_d = S_ROM2;
            S_ROM2:  state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data == TERMINATOR) begin
                    state_d = S_FINISH;
                end else if (!is_allophone(rom_data)) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    allo_d  = rom_data[5:0];
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!core_busy) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_clear = 1'b1;
                state_d  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (core_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    to_en = 1'b1;
                    if (to_expired) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!core_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                addr_d = addr_q + 1'b1;
                len_d  = len_q + 1'b1;
                if (len_d == LEN_W'(MAX_LEN)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_ROM1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any phrase at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            allo_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            allo_q  <= allo_d;
            err_q   <= err_d;
        end
    end

    assign rom_addr     = addr_q;
    assign allophone    = allo_q;
    assign data_arrived = (state_q == S_ISSUE);
    assign done         = (state_q == S_FINISH);
    assign seq_busy     = (state_q != S_IDLE);
    assign error        = err_q;

endmodule

// File: tb/tb_allophone_sequencer.sv
// Randomised self-checking bench: phrase ROM model, playback-core model and
// a phrase-level reference model of what the sequencer should emit.
module tb_allophone_sequencer;

    localparam int ADDR_W  = 10;
    localparam int MAX_LEN = 32;
    localparam int ROM_SZ  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] phrase_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              core_busy = 1'b0;
    logic [5:0]        allophone;
    logic              data_arrived;
    logic              seq_busy;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Phrase ROM contents and its 2-cycle read pipeline.
    logic [7:0] mem [0:ROM_SZ-1];
    logic [7:0] rd1 = 8'h00;
    logic [7:0] rd2 = 8'h00;

    // Playback core model controls.
    bit core_ack_en = 1'b1;
    int hold_fixed  = 0;
    int core_dly    = 0;
    int core_hold   = 0;
    bit core_pend   = 1'b0;

    // Reference model results.
    int exp_q[$];
    bit exp_err;
    int exp_addr;
    int exp_lat;
    int exp_empty_lat;

    allophone_sequencer #(
        .ADDR_W      (ADDR_W),
        .MAX_LEN     (MAX_LEN),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .phrase_addr  (phrase_addr),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .core_busy    (core_busy),
        .allophone    (allophone),
        .data_arrived (data_arrived),
        .seq_busy     (seq_busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM: data appears two cycles after the address is presented.
    always @(posedge clk) begin
        rd1 <= mem[rom_addr];
        rd2 <= rd1;
    end
    assign rom_data = rd2;

    // Core: after a data_arrived pulse, raise busy within 0-3 cycles and hold
    // it for at least 4 cycles. Not tied to the sequencer reset, so a core
    // mid-allophone keeps going when the sequencer is reset.
    always @(posedge clk) begin
        if (data_arrived && core_ack_en && !core_busy && !core_pend) begin
            core_pend <= 1'b1;
            core_dly  <= $urandom_range(0, 3);
            core_hold <= (hold_fixed != 0) ? hold_fixed : $urandom_range(4, 12);
        end else if (core_pend) begin
            if (core_dly == 0) begin
                core_busy <= 1'b1;
                core_pend <= 1'b0;
            end else begin
                core_dly <= core_dly - 1;
            end
        end else if (core_busy) begin
            if (core_hold <= 1) core_busy <= 1'b0;
            else core_hold <= core_hold - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Phrase-level reference: walk the ROM from addr applying the entry rules.
    task automatic model(input int addr, input bit ack_en);
        int a;
        int k;
        bit seen_code;
        bit term;
        logic [7:0] d;
        exp_q.delete();
        exp_err   = 1'b0;
        a         = addr;
        k         = 0;
        seen_code = 1'b0;
        term      = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            d = mem[a];
            if (d == 8'hFF) begin
                term = 1'b1;
                break;
            end
            if (d > 8'h3F) begin
                exp_err = 1'b1;
                if (!seen_code) k++;
            end else begin
                exp_q.push_back(int'(d));
                seen_code = 1'b1;
                if (!ack_en) begin
                    exp_err = 1'b1;
                    break;
                end
            end
            a = (a + 1) % ROM_SZ;
            if (i == MAX_LEN - 1) exp_err = 1'b1;
        end
        exp_addr = a;
        // Each skipped invalid entry costs DECODE, NEXT, ROM1, ROM2.
        exp_lat       = 5 + 4 * k;
        exp_empty_lat = (term && exp_q.size() == 0) ? 4 + 4 * k : -1;
    endtask

    task automatic run_phrase(input string name, input int addr, input bit ack_en,
                              input bit hold_start, input bit check_lat);
        int got[$];
        int start_cyc, first_da, last_da, done_cyc, n_done, cycles;
        int fin_addr;
        bit fin_err, allo_bad, busy_bad;
        logic [5:0] held;
        core_ack_en = ack_en;
        model(addr, ack_en);
        first_da = -1; last_da = -1; done_cyc = -1; n_done = 0; cycles = 0;
        fin_addr = 0; fin_err = 1'b0; allo_bad = 1'b0; busy_bad = 1'b0; held = '0;
        @(negedge clk);
        phrase_addr = ADDR_W'(addr);
        start       = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        if (hold_start) phrase_addr = ADDR_W'($urandom);
        else start = 1'b0;
        while (n_done == 0 && cycles < 4000) begin
            if (data_arrived) begin
                got.push_back(int'(allophone));
                if (first_da < 0) first_da = cyc;
                last_da = cyc;
                held = allophone;
            end
            if (core_busy && got.size() > 0 && allophone != held) allo_bad = 1'b1;
            if (!seq_busy) busy_bad = 1'b1;
            if (done) begin
                n_done   = 1;
                done_cyc = cyc;
                fin_addr = int'(rom_addr);
                fin_err  = error;
                start    = 1'b0;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        check({name, " done_seen"}, n_done, 1);
        @(negedge clk);
        check({name, " idle_after"}, {seq_busy, done}, 2'b00);
        check({name, " n_codes"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s code%0d", name, i), (i < got.size()) ? got[i] : 32'hDEAD, exp_q[i]);
        check({name, " error"}, fin_err, exp_err);
        check({name, " rom_addr"}, fin_addr, exp_addr);
        check({name, " allo_stable"}, allo_bad, 1'b0);
        check({name, " seq_busy_held"}, busy_bad, 1'b0);
        if (check_lat && exp_q.size() > 0)
            check({name, " first_latency"}, first_da - start_cyc, exp_lat);
        if (check_lat && exp_empty_lat >= 0)
            check({name, " empty_latency"}, done_cyc - start_cyc, exp_empty_lat);
        if (!ack_en && exp_q.size() > 0)
            check({name, " ack_timeout"}, done_cyc - last_da, 15);
        $display("phrase %s addr=%03h codes=%0d/%0d err=%0b end_addr=%03h",
                 name, addr, got.size(), exp_q.size(), fin_err, fin_addr);
    endtask

    initial begin
        int a;
        int n;
        int waited;
        reset       = 1'b1;
        start       = 1'b0;
        phrase_addr = '0;
        for (int i = 0; i < ROM_SZ; i++) mem[i] = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_outputs", {rom_addr, allophone, data_arrived, seq_busy, done, error}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Two-code phrase, long busy from the core.
        mem[10'h010] = 8'h05; mem[10'h011] = 8'h1A; mem[10'h012] = 8'hFF;
        hold_fixed = 20;
        run_phrase("basic", 10'h010, 1'b1, 1'b0, 1'b1);
        hold_fixed = 0;

        // Address wrap across the top of the ROM.
        mem[10'h3FE] = 8'h07; mem[10'h3FF] = 8'h08; mem[10'h000] = 8'hFF;
        run_phrase("wrap", 10'h3FE, 1'b1, 1'b0, 1'b1);

        // Invalid entry skipped, error reported.
        mem[10'h080] = 8'h05; mem[10'h081] = 8'h80; mem[10'h082] = 8'h06; mem[10'h083] = 8'hFF;
        run_phrase("invalid", 10'h080, 1'b1, 1'b0, 1'b1);

        // Empty phrase.
        mem[10'h0C0] = 8'hFF;
        run_phrase("empty", 10'h0C0, 1'b1, 1'b0, 1'b1);

        // No terminator: forced stop at MAX_LEN.
        for (int i = 0; i < 40; i++) mem[10'h100 + i] = 8'h01;
        run_phrase("maxlen", 10'h100, 1'b1, 1'b0, 1'b1);

        // Core never acknowledges; start held high throughout.
        mem[10'h200] = 8'h11; mem[10'h201] = 8'h12; mem[10'h202] = 8'hFF;
        run_phrase("no_ack", 10'h200, 1'b0, 1'b1, 1'b1);

        // Reset while waiting for the core to finish.
        core_ack_en = 1'b1;
        hold_fixed  = 20;
        @(negedge clk);
        phrase_addr = 10'h010;
        start       = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!core_busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("reset_test busy_seen", core_busy, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_midphrase", {rom_addr, allophone, data_arrived, seq_busy, done, error}, 0);
        @(negedge clk);
        reset = 1'b0;
        hold_fixed = 0;
        run_phrase("after_reset", 10'h010, 1'b1, 1'b0, 1'b0);

        // Random phrases, some with start held high mid-phrase.
        for (int t = 0; t < 12; t++) begin
            a = $urandom_range(0, ROM_SZ - 1);
            n = $urandom_range(0, 8);
            for (int k = 0; k < n; k++)
                mem[(a + k) % ROM_SZ] = ($urandom_range(0, 9) == 0) ?
                    8'($urandom_range(8'h40, 8'hFE)) : 8'($urandom_range(0, 63));
            mem[(a + n) % ROM_SZ] = 8'hFF;
            run_phrase($sformatf("rand%0d", t), a, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
